if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_stage_if_id.sv | 39 +++
 rtl/if_stage.sv | 78 +++++++
 tb/tb_if_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, chip-enable encodings and reset address for the fetch stage.
package if_stage_pkg;

  localparam int INSTADDRBUS = 32;
  localparam int INSTBUS     = 32;

  localparam logic CHIPENABLE  = 1'b1;
  localparam logic CHIPDISABLE = 1'b0;

  localparam logic [INSTBUS-1:0]     NOP          = '0;
  localparam logic [INSTADDRBUS-1:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [INSTADDRBUS-1:0] word_align(input logic [INSTADDRBUS-1:0] addr);
    return {addr[INSTADDRBUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register: flush clears, IF stall injects a bubble, ID stall holds.
module if_id
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic [INSTADDRBUS-1:0] pc,
  input  logic [INSTBUS-1:0]     inst,
  input  logic                   valid,
  output logic [INSTADDRBUS-1:0] id_pc,
  output logic [INSTBUS-1:0]     id_inst,
  output logic                   id_valid
);

  logic [INSTADDRBUS-1:0] pc_p1;
  logic [INSTBUS-1:0]     inst_p1;
  logic                   vld_p1;

  // stage boundary IF -> ID
  always_ff @(posedge clk) begin
    if (rst || flush || (stall_if && !stall_id)) begin
      pc_p1   <= '0;
      inst_p1 <= NOP;
      vld_p1  <= 1'b0;
    end else if (!stall_id) begin
      pc_p1   <= pc;
      inst_p1 <= inst;
      vld_p1  <= valid;
    end
  end

  assign id_pc    = pc_p1;
  assign id_inst  = inst_p1;
  assign id_valid = vld_p1;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC sequencing with flush/stall/branch priority and a one-entry
// pending-branch slot for branches resolved while IF is stalled.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INSTADDRBUS-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic                   flush,
  input  logic [INSTADDRBUS-1:0] new_pc,
  input  logic                   branch_flag,
  input  logic [INSTADDRBUS-1:0] branch_target,
  output logic                   rom_ce,
  output logic [INSTADDRBUS-1:0] rom_addr,
  input  logic [INSTBUS-1:0]     rom_inst,
  output logic [INSTADDRBUS-1:0] id_pc,
  output logic [INSTBUS-1:0]     id_inst,
  output logic                   id_valid
);

  logic                   ce_p0;
  logic [INSTADDRBUS-1:0] pc_p0;
  logic [INSTADDRBUS-1:0] pc_next;
  logic                   pend_vld;
  logic [INSTADDRBUS-1:0] pend_target;

  always_comb begin
    pc_next = pc_p0 + 32'd4;
    if (flush)            pc_next = word_align(new_pc);
    else if (stall_if)    pc_next = pc_p0;
    else if (pend_vld)    pc_next = pend_target;
    else if (branch_flag) pc_next = word_align(branch_target);
  end

  // stage boundary PC -> IF; PC stays at RESET_PC until the ROM is enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_p0    <= CHIPDISABLE;
      pc_p0    <= RESET_PC;
      pend_vld <= 1'b0;
    end else begin
      ce_p0 <= CHIPENABLE;
      pc_p0 <= (ce_p0 == CHIPDISABLE) ? RESET_PC : pc_next;
      if (flush)
        pend_vld <= 1'b0;
      else if (stall_if && branch_flag && ce_p0 == CHIPENABLE)
        pend_vld <= 1'b1;
      else if (!stall_if)
        pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (stall_if && branch_flag)
      pend_target <= word_align(branch_target);
  end

  assign rom_ce   = ce_p0;
  assign rom_addr = (ce_p0 == CHIPENABLE) ? pc_p0 : '0;

  if_id u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall_if (stall_if),
    .stall_id (stall_id),
    .pc       (pc_p0),
    .inst     (rom_inst),
    .valid    (ce_p0),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, branch, stall, flush, wrap.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall_if, stall_id, flush, branch_flag;
  logic [31:0] new_pc, branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst, id_pc, id_inst;
  logic        id_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return 32'h1000_0000 + a;
    endcase
  endfunction

  assign rom_inst = rom_f(rom_addr);

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall_if = 0; stall_id = 0; flush = 0; branch_flag = 0;
    new_pc = '0; branch_target = '0;
  endtask

  initial begin
    rst = 1; idle();
    tick(); tick();
    check("rst_ce", {31'b0, rom_ce}, 32'd0);
    check("rst_addr", rom_addr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);

    // reset release: first enabled fetch at RESET_PC
    rst = 0;
    tick();
    check("rel_ce", {31'b0, rom_ce}, 32'd1);
    check("rel_addr", rom_addr, 32'h0);
    tick();
    check("seq_addr4", rom_addr, 32'h4);
    check("seq_inst11", id_inst, 32'h11);
    check("seq_valid0", {31'b0, id_valid}, 32'd1);
    tick();
    check("seq_addr8", rom_addr, 32'h8);
    check("seq_inst22", id_inst, 32'h22);
    tick();
    check("seq_addrC", rom_addr, 32'hC);
    check("seq_inst33", id_inst, 32'h33);
    check("seq_pc8", id_pc, 32'h8);

    // stall three cycles at C, branch pulse to 0x80 mid-stall
    stall_if = 1;
    tick();
    check("stl1_addr", rom_addr, 32'hC);
    check("stl1_bubble", {31'b0, id_valid}, 32'd0);
    branch_flag = 1; branch_target = 32'h80;
    tick();
    branch_flag = 0; branch_target = '0;
    check("stl2_addr", rom_addr, 32'hC);
    check("stl2_bubble_pc", id_pc, 32'h0);
    tick();
    check("stl3_addr", rom_addr, 32'hC);
    check("stl3_bubble_inst", id_inst, 32'h0);
    stall_if = 0;
    tick();
    check("pend_addr80", rom_addr, 32'h80);
    check("pend_id_pcC", id_pc, 32'hC);
    check("pend_inst44", id_inst, 32'h44);
    check("pend_valid", {31'b0, id_valid}, 32'd1);
    tick();
    check("pend_cleared", rom_addr, 32'h84);

    // flush with simultaneous branch and stall, pending previously set
    stall_if = 1; branch_flag = 1; branch_target = 32'h100;
    tick();
    flush = 1; new_pc = 32'h20; branch_target = 32'h200;
    tick();
    check("fl_addr", rom_addr, 32'h20);
    check("fl_valid", {31'b0, id_valid}, 32'd0);
    check("fl_id_pc", id_pc, 32'h0);
    idle();
    tick();
    check("fl_pend_clr", rom_addr, 32'h24);
    check("fl_id_pc20", id_pc, 32'h20);
    check("fl_id_inst", id_inst, 32'h1000_0020);

    // both stalls hold IF/ID and PC
    stall_if = 1; stall_id = 1;
    tick(); tick();
    check("hold_addr", rom_addr, 32'h24);
    check("hold_id_pc", id_pc, 32'h20);
    check("hold_inst", id_inst, 32'h1000_0020);
    check("hold_valid", {31'b0, id_valid}, 32'd1);
    idle();
    tick();
    check("resume_addr", rom_addr, 32'h28);
    check("resume_id_pc", id_pc, 32'h24);

    // flush to unaligned 0xB, then branch with delay slot at PC=8
    flush = 1; new_pc = 32'hB;
    tick();
    idle();
    check("align_flush", rom_addr, 32'h8);
    branch_flag = 1; branch_target = 32'h43;
    tick();
    idle();
    check("br_addr40", rom_addr, 32'h40);
    check("br_slot_pc", id_pc, 32'h8);
    check("br_slot_inst", id_inst, 32'h33);
    check("br_slot_valid", {31'b0, id_valid}, 32'd1);

    // PC wrap
    flush = 1; new_pc = 32'hFFFF_FFFC;
    tick();
    idle();
    check("wrap_top", rom_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_zero", rom_addr, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_id_inst", id_inst, 32'h0FFF_FFFC);

    // reset mid-stall with pending branch
    stall_if = 1; branch_flag = 1; branch_target = 32'h300;
    tick();
    rst = 1;
    tick();
    check("mrst_ce", {31'b0, rom_ce}, 32'd0);
    check("mrst_addr", rom_addr, 32'h0);
    check("mrst_valid", {31'b0, id_valid}, 32'd0);
    rst = 0; idle();
    tick();
    check("mrst_ce_on", {31'b0, rom_ce}, 32'd1);
    check("mrst_pc", rom_addr, 32'h0);
    tick();
    check("mrst_no_pend", rom_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
